// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for one shared tristate line: one-hot enables, a fixed dead time after release.
// Optional TBA_TIMEOUT_EN caps bursts at MAX_BURST owned cycles and pulses TOUT on a forced release.
module tristate_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int TURN_CYC  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] ENB,
    output logic [NREQ-1:0] GNT,
    output logic            BUSY,
    output logic            TOUT
);

    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam logic [NREQ-1:0] LSB_ONE = NREQ'(1);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("tristate_bus_arbiter: NREQ must be 2..8");
    end
    if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
        $error("tristate_bus_arbiter: TURN_CYC must be 1..15");
    end
    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_burst
        $error("tristate_bus_arbiter: MAX_BURST must be 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   last_q;
    logic [TW-1:0]   turn_cnt_q;
    logic [NREQ-1:0] enb_q;
    logic            busy_q;

`ifdef TBA_TIMEOUT_EN
    logic [7:0]      burst_q;
    logic            tout_q;
`endif

    logic [OW-1:0]   win_d;
    logic            win_vld;
    logic [OW-1:0]   cand;

    // Scan from farthest to nearest after last_q so the nearest requester is written last and wins.
    always_comb begin
        win_d   = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = OW'((int'(last_q) + k) % NREQ);
            if (REQ[cand]) begin
                win_vld = 1'b1;
                win_d   = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= OW'(NREQ - 1);
            turn_cnt_q <= '0;
            enb_q      <= '0;
            busy_q     <= 1'b0;
`ifdef TBA_TIMEOUT_EN
            burst_q    <= '0;
            tout_q     <= 1'b0;
`endif
        end else begin
`ifdef TBA_TIMEOUT_EN
            tout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q <= DRIVE;
                        owner_q <= win_d;
                        enb_q   <= LSB_ONE << win_d;
                        busy_q  <= 1'b1;
`ifdef TBA_TIMEOUT_EN
                        burst_q <= 8'd1;
`endif
                    end else begin
                        enb_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (!REQ[owner_q]) begin
                        state_q    <= TURN;
                        enb_q      <= '0;
                        busy_q     <= 1'b1;
                        last_q     <= owner_q;
                        turn_cnt_q <= '0;
`ifdef TBA_TIMEOUT_EN
                        burst_q    <= '0;
                    end else if (burst_q == 8'(MAX_BURST)) begin
                        // Forced end: recording the owner as last_q lets the rotation move past it.
                        state_q    <= TURN;
                        enb_q      <= '0;
                        busy_q     <= 1'b1;
                        last_q     <= owner_q;
                        turn_cnt_q <= '0;
                        burst_q    <= '0;
                        tout_q     <= 1'b1;
                    end else begin
                        burst_q    <= burst_q + 8'd1;
`endif
                    end
                end

                TURN: begin
                    enb_q <= '0;
                    if (turn_cnt_q == TW'(TURN_CYC - 1)) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        turn_cnt_q <= '0;
                    end else begin
                        busy_q     <= 1'b1;
                        turn_cnt_q <= turn_cnt_q + TW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    enb_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ENB  = enb_q;
    assign GNT  = enb_q;
    assign BUSY = busy_q;

`ifdef TBA_TIMEOUT_EN
    assign TOUT = tout_q;
`else
    assign TOUT = 1'b0;
`endif

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one tristate line; legal range 2..8.
REQ-002 Parameter TURN_CYC, default 1: dead cycles with all enables low after each release; legal range 1..15.
REQ-003 Parameter MAX_BURST, default 16: maximum consecutive owned cycles; used only with TBA_TIMEOUT_EN; legal range 2..255.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-006 REQ  input  NREQ  per-requester bus request; level-sensitive; held high for the whole transfer.
REQ-007 ENB  output  NREQ  per-requester tristate driver enable; at most one bit high.
REQ-008 GNT  output  NREQ  per-requester grant; equals ENB.
REQ-009 BUSY  output  1  high while any ENB bit is high or a turnaround is in progress.
REQ-010 TOUT  output  1  one-cycle pulse when a burst is forcibly ended; tied low without TBA_TIMEOUT_EN.

Function
REQ-011 All outputs shall be registered; no combinational path from REQ to ENB, GNT, BUSY or TOUT.
REQ-012 The FSM shall have states IDLE, DRIVE and TURN.
REQ-013 IDLE: if REQ is nonzero at an edge, the FSM enters DRIVE and raises the winner's ENB/GNT bit on that edge; otherwise it stays in IDLE with ENB=0.
REQ-014 The winner is chosen round-robin, searching upward with wrap from index (last_owner+1) mod NREQ; after reset, last_owner=NREQ-1, so index 0 has highest priority.
REQ-015 DRIVE: ENB stays on the owner while REQ[owner] is high; if REQ[owner] is low at an edge, ENB goes to 0 on that edge, last_owner updates and the FSM enters TURN.
REQ-016 Other requests arriving during DRIVE or TURN shall not preempt the owner or shorten the turnaround.
REQ-017 TURN shall last exactly TURN_CYC cycles with ENB=0 and BUSY=1, then go to IDLE; the gap between owners is therefore at least TURN_CYC+1 cycles with ENB=0.
REQ-018 A requester that drops and reasserts REQ during TURN shall compete normally in IDLE.
REQ-019 A single requester requesting continuously shall be regranted after each turnaround.
REQ-020 The turnaround counter shall be ceil(log2(TURN_CYC+1)) bits and shall not wrap past TURN_CYC-1.

Reset
REQ-021 During RST=1: state=IDLE, ENB=0, GNT=0, BUSY=0, TOUT=0, last_owner=NREQ-1, all counters=0.
REQ-022 Reset asserted during DRIVE or TURN shall take effect at the next edge, with no extra turnaround.
REQ-023 The first grant after reset release shall be possible on the first edge with RST=0.

Configuration
REQ-024 Macro TBA_TIMEOUT_EN: when defined, an 8-bit burst counter counts owned cycles; when it reaches MAX_BURST with REQ[owner] still high, ENB goes to 0, TOUT pulses for one cycle and the FSM enters TURN.
REQ-025 After a forced end under TBA_TIMEOUT_EN, round-robin shall advance past the timed-out owner.
REQ-026 Without TBA_TIMEOUT_EN: no burst counter, TOUT is constant 0, and a burst lasts as long as REQ[owner] stays high.

Verification
REQ-027 Reset, then REQ=4'b0001 held 3 cycles and then dropped -> ENB=0001 for exactly 3 cycles, then TURN_CYC+1 cycles of ENB=0, BUSY=1 during TURN.
REQ-028 REQ=4'b1111 held, each owner drops after 2 cycles -> grant order 0,1,2,3,0, with no overlap and a gap of at least TURN_CYC+1 cycles between owners.
REQ-029 Owner 2 in DRIVE while REQ[0] rises -> ENB stays 0100 until REQ[2] falls; the next grant goes to index 3 if requesting, else 0.
REQ-030 RST pulsed mid-DRIVE with ENB=0010 -> at the next edge ENB=0, BUSY=0; after release with REQ=1111, the grant goes to index 0.
REQ-031 With TBA_TIMEOUT_EN, MAX_BURST=4, REQ=0001 held -> ENB high for 4 cycles, one TOUT pulse, turnaround, then regrant to index 0.
REQ-032 All cycles of all scenarios -> ENB is one-hot or zero, and GNT equals ENB.
